// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front-end: default sizes, the I/Q sample
// type, the framer state encoding and the hop sanitising helper.
package fft_pkg;

  localparam int FFT_N    = 32;
  localparam int SAMPLE_W = 32;

  // One complex sample as stored in a tap: real part in the upper half.
  typedef struct packed {
    logic [SAMPLE_W-1:0] i;
    logic [SAMPLE_W-1:0] q;
  } iq_t;

  // FILL: window not yet complete since reset/flush; RUN: sliding frames.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } frame_state_e;

  // A hop of zero or one beyond the window length means "one full window".
  function automatic int unsigned eff_hop(input int unsigned hop, input int unsigned n);
    if ((hop == 32'd0) || (hop > n)) begin
      return n;
    end else begin
      return hop;
    end
  endfunction

endpackage

// File: rtl/fft_tap_line.sv
// N-deep delay line of complex samples. Shifts only when enabled, clears
// synchronously on clr, and exposes every tap in parallel (tap 0 newest,
// at the least significant slice).
module fft_tap_line
  import fft_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int W = SAMPLE_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           clr,
  input  logic [W-1:0]   d_i,
  input  logic [W-1:0]   d_q,
  output logic [N*W-1:0] taps_i,
  output logic [N*W-1:0] taps_q
);

  logic [N*W-1:0] i_r;
  logic [N*W-1:0] q_r;

  // Shift the new sample into slice 0; older samples move one slice up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_r <= '0;
      q_r <= '0;
    end else if (clr) begin
      i_r <= '0;
      q_r <= '0;
    end else if (en) begin
      i_r <= {i_r[(N-1)*W-1:0], d_i};
      q_r <= {q_r[(N-1)*W-1:0], d_q};
    end
  end

  assign taps_i = i_r;
  assign taps_q = q_r;

endmodule

// File: rtl/fft_window_framer.sv
// Sample-window buffer in front of the parallel FFT core. Collects a serial
// I/Q stream into an N-tap delay line and hands the whole window to the FFT
// every hop accepted samples once the line has filled. While a frame waits
// for the FFT, input is back-pressured so the window stays stable.
module fft_window_framer
  import fft_pkg::*;
#(
  parameter int N    = FFT_N,
  parameter int W    = SAMPLE_W,
  parameter int HOPW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W-1:0]    s_i,
  input  logic [W-1:0]    s_q,
  input  logic [HOPW-1:0] hop,
  input  logic            flush,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [N*W-1:0]  win_i,
  output logic [N*W-1:0]  win_q,
  output logic            filled
);

  localparam int HW1 = HOPW + 1;
  localparam logic [HOPW-1:0] N_CNT = HOPW'(N);
  localparam logic [HOPW:0]   N_EXT = HW1'(N);

  frame_state_e    state_r;
  logic [HOPW-1:0] fill_cnt_r;
  logic [HOPW-1:0] hop_cnt_r;
  logic [HOPW-1:0] hop_q_r;
  logic            m_valid_r;
  logic            filled_r;

  logic            accept_s;
  logic            shift_s;
  logic [HOPW:0]   fill_nxt_s;
  logic [HOPW:0]   hop_nxt_s;
  logic [HOPW-1:0] hop_eff_s;
  logic            frame_done_s;

  // Only a pending, unaccepted frame blocks the input; a frame being taken
  // this cycle leaves room for a new sample in the same cycle.
  assign s_ready  = ~m_valid_r | m_ready;
  assign accept_s = s_valid & s_ready;
  assign shift_s  = accept_s & ~flush;

  assign fill_nxt_s = {1'b0, fill_cnt_r} + {{HOPW{1'b0}}, 1'b1};
  assign hop_nxt_s  = {1'b0, hop_cnt_r}  + {{HOPW{1'b0}}, 1'b1};
  assign hop_eff_s  = HOPW'(eff_hop(32'(hop), N));

  // Decide whether the sample accepted this cycle completes a frame.
  always_comb begin
    frame_done_s = 1'b0;
    case (state_r)
      FILL: begin
        if (shift_s && (fill_nxt_s == N_EXT)) begin
          frame_done_s = 1'b1;
        end else begin
          frame_done_s = 1'b0;
        end
      end
      RUN: begin
        if (shift_s && (hop_nxt_s == {1'b0, hop_q_r})) begin
          frame_done_s = 1'b1;
        end else begin
          frame_done_s = 1'b0;
        end
      end
      default: frame_done_s = 1'b0;
    endcase
  end

  // Framing control: fill/hop counting, frame handshake, flush restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= FILL;
      fill_cnt_r <= '0;
      hop_cnt_r  <= '0;
      hop_q_r    <= N_CNT;
      m_valid_r  <= 1'b0;
      filled_r   <= 1'b0;
    end else if (flush) begin
      state_r    <= FILL;
      fill_cnt_r <= '0;
      hop_cnt_r  <= '0;
      hop_q_r    <= hop_eff_s;
      m_valid_r  <= 1'b0;
      filled_r   <= 1'b0;
    end else begin
      if (shift_s) begin
        case (state_r)
          FILL: begin
            if (frame_done_s) begin
              // Fill count parks at N until the next flush/reset.
              fill_cnt_r <= N_CNT;
              filled_r   <= 1'b1;
              hop_cnt_r  <= '0;
              hop_q_r    <= hop_eff_s;
              state_r    <= RUN;
            end else begin
              fill_cnt_r <= fill_nxt_s[HOPW-1:0];
            end
          end
          RUN: begin
            if (frame_done_s) begin
              hop_cnt_r <= '0;
              hop_q_r   <= hop_eff_s;
            end else begin
              hop_cnt_r <= hop_nxt_s[HOPW-1:0];
            end
          end
          default: state_r <= FILL;
        endcase
      end
      // A completing accept re-arms the frame even if the FFT takes the
      // current one in the same cycle (back-to-back frames at hop 1).
      if (frame_done_s) begin
        m_valid_r <= 1'b1;
      end else if (m_ready) begin
        m_valid_r <= 1'b0;
      end
    end
  end

  fft_tap_line #(
    .N (N),
    .W (W)
  ) u_taps (
    .clk    (clk),
    .reset  (reset),
    .en     (shift_s),
    .clr    (flush),
    .d_i    (s_i),
    .d_q    (s_q),
    .taps_i (win_i),
    .taps_q (win_q)
  );

  assign m_valid = m_valid_r;
  assign filled  = filled_r;

endmodule
